xbar_perm_pipe: RTL

XBAR_PERM_PIPE -- requirements
Module: xbar_perm_pipe

---
 rtl/xbar_pkg.sv | 14 +
 rtl/xbar_sel_decode.sv | 26 ++
 rtl/xbar_perm_pipe.sv | 101 ++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// xbar_pkg: crossbar mode encoding, default lane geometry, tag width helper
package xbar_pkg;
  typedef enum logic [1:0] {
    MODE_GATHER  = 2'd0,
    MODE_BCAST   = 2'd1,
    MODE_ROTATE  = 2'd2,
    MODE_REVERSE = 2'd3
  } xbar_mode_t;
  localparam int XBAR_DEF_SIZE = 32;
  localparam int XBAR_DEF_DWIDTH = 16;
  function automatic int tag_width(input int size);
    return $clog2(size);
  endfunction
endpackage

// File: rtl/xbar_sel_decode.sv
// xbar_sel_decode: mode+sel -> per-lane source index (src) and GATHER duplicate-select flag (dup)
module xbar_sel_decode
  import xbar_pkg::*;
#(
  parameter int SIZE = XBAR_DEF_SIZE,
  localparam int TW = tag_width(SIZE)
) (
  input  xbar_mode_t         mode,
  input  logic [SIZE*TW-1:0] sel,
  output logic [SIZE*TW-1:0] src,
  output logic               dup
);
  logic [TW-1:0] s0;
  assign s0 = sel[TW-1:0];
  always_comb begin
    src = '0;
    dup = 1'b0;
    for (int i = 0; i < SIZE; i++) begin
      src[i*TW +: TW] = mode == MODE_GATHER ? sel[i*TW +: TW] :
                        mode == MODE_BCAST  ? s0 :
                        mode == MODE_ROTATE ? s0 + TW'(i) : TW'(SIZE - 1 - i);
      for (int j = i + 1; j < SIZE; j++) dup = dup | (sel[i*TW +: TW] == sel[j*TW +: TW]);
    end
    dup = dup & (mode == MODE_GATHER);
  end
endmodule

// File: rtl/xbar_perm_pipe.sv
// xbar_perm_pipe: LATENCY-stage lane permutation pipe; in_* valid/ready beat in, out_* valid/ready beat out, flush, beat_count
module xbar_perm_pipe
  import xbar_pkg::*;
#(
  parameter int SIZE = XBAR_DEF_SIZE,
  parameter int DWIDTH = XBAR_DEF_DWIDTH,
  parameter int LATENCY = 2,
  localparam int TAGWIDTH = $clog2(SIZE)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SIZE*DWIDTH-1:0]   in_data,
  input  logic [SIZE*TAGWIDTH-1:0] in_sel,
  input  logic [1:0]               in_mode,
  input  logic [SIZE-1:0]          in_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [SIZE*DWIDTH-1:0]   out_data,
  output logic [SIZE-1:0]          out_mask,
  output logic                     out_perm_err,
  output logic [31:0]              beat_count
);
  localparam int DW = SIZE * DWIDTH;
  localparam int TW = SIZE * TAGWIDTH;
  logic [TW-1:0] src;
  logic dup;
  logic [LATENCY-1:0] rdy, v_d, v_q, err_d, err_q;
  logic [LATENCY-1:0][DW-1:0] data_d, data_q;
  logic [LATENCY-1:0][TW-1:0] src_d, src_q;
  logic [LATENCY-1:0][SIZE-1:0] mask_d, mask_q;
  logic [31:0] beat_count_d, beat_count_q;
  logic [DWIDTH-1:0] lane [SIZE];
  xbar_sel_decode #(.SIZE(SIZE)) u_dec (
    .mode(xbar_mode_t'(in_mode)),
    .sel (in_sel),
    .src (src),
    .dup (dup)
  );
  always_comb begin
    logic r;
    for (int k = 0; k < LATENCY; k++) begin
      r = out_ready;
      for (int j = k; j < LATENCY; j++) r = r | ~v_q[j];
      rdy[k] = r;
    end
    in_ready = rdy[0] & ~flush;
    v_d = v_q;
    data_d = data_q;
    src_d = src_q;
    mask_d = mask_q;
    err_d = err_q;
    if (rdy[0]) begin
      v_d[0] = in_valid & in_ready;
      data_d[0] = in_data;
      src_d[0] = src;
      mask_d[0] = in_mask;
      err_d[0] = dup;
    end
    for (int k = 1; k < LATENCY; k++) begin
      if (rdy[k]) begin
        v_d[k] = v_q[k-1];
        data_d[k] = data_q[k-1];
        src_d[k] = src_q[k-1];
        mask_d[k] = mask_q[k-1];
        err_d[k] = err_q[k-1];
      end
    end
    v_d = flush ? '0 : v_d;
    beat_count_d = beat_count_q + 32'(out_valid & out_ready);
  end
  // mux sits after the last register; source indices travel with the beat
  always_comb begin
    for (int i = 0; i < SIZE; i++) lane[i] = data_q[LATENCY-1][i*DWIDTH +: DWIDTH];
    for (int i = 0; i < SIZE; i++)
      out_data[i*DWIDTH +: DWIDTH] = mask_q[LATENCY-1][i] ? lane[src_q[LATENCY-1][i*TAGWIDTH +: TAGWIDTH]] : '0;
  end
  assign out_valid = v_q[LATENCY-1];
  assign out_mask = mask_q[LATENCY-1];
  assign out_perm_err = v_q[LATENCY-1] & err_q[LATENCY-1];
  assign beat_count = beat_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      data_q <= '0;
      src_q <= '0;
      mask_q <= '0;
      err_q <= '0;
      beat_count_q <= '0;
    end else begin
      v_q <= v_d;
      data_q <= data_d;
      src_q <= src_d;
      mask_q <= mask_d;
      err_q <= err_d;
      beat_count_q <= beat_count_d;
    end
  end
endmodule
